// File: rtl/exhaustive_vector_sequencer.sv
// Exhaustive stimulus sequencer: sweeps every input vector, samples the DUT
// response after a settle delay, streams records and folds them into a MISR.
module exhaustive_vector_sequencer #(
    parameter int                   N_WIDTH       = 3,
    parameter int                   OUT_WIDTH     = 1,
    parameter int                   SETTLE_CYCLES = 1,
    parameter int                   SIG_WIDTH     = 16,
    parameter logic [SIG_WIDTH-1:0] SIG_POLY      = 16'h1021,
    parameter logic [SIG_WIDTH-1:0] SIG_SEED      = 16'h0000
) (
    input  logic                 CK,
    input  logic                 reset,
    input  logic                 start,
    output logic [N_WIDTH-1:0]   vec_out,
    input  logic [OUT_WIDTH-1:0] dut_resp,
    output logic                 rec_valid,
    input  logic                 rec_ready,
    output logic [N_WIDTH-1:0]   rec_vec,
    output logic [OUT_WIDTH-1:0] rec_resp,
    output logic                 busy,
    output logic                 done,
    output logic [SIG_WIDTH-1:0] signature,
    output logic [N_WIDTH:0]     ones_count
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [N_WIDTH-1:0] LAST_VEC = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t                 state_q;
    logic [N_WIDTH-1:0]     idx_q;
    logic [CW-1:0]          cnt_q;
    logic [N_WIDTH-1:0]     vec_q;
    logic                   valid_q;
    logic [N_WIDTH-1:0]     rvec_q;
    logic [OUT_WIDTH-1:0]   rresp_q;
    logic                   busy_q;
    logic                   done_q;
    logic [SIG_WIDTH-1:0]   sig_q;
    logic [N_WIDTH:0]       ones_q;

    logic [SIG_WIDTH-1:0]   sig_d;
    logic [N_WIDTH:0]       ones_d;

    // Serial MISR step with the current response folded into the low bits
    always_comb begin
        sig_d = {sig_q[SIG_WIDTH-2:0], 1'b0}
              ^ (sig_q[SIG_WIDTH-1] ? SIG_POLY : '0)
              ^ SIG_WIDTH'(dut_resp);
        ones_d = ones_q + {{N_WIDTH{1'b0}}, dut_resp[0]};
    end

    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            vec_q   <= '0;
            valid_q <= 1'b0;
            rvec_q  <= '0;
            rresp_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sig_q   <= SIG_SEED;
            ones_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        idx_q   <= '0;
                        sig_q   <= SIG_SEED;
                        ones_q  <= '0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    vec_q   <= idx_q;
                    cnt_q   <= CW'(SETTLE_CYCLES - 1);
                    state_q <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (cnt_q == '0) begin
                        rresp_q <= dut_resp;
                        rvec_q  <= idx_q;
                        sig_q   <= sig_d;
                        ones_q  <= ones_d;
                        valid_q <= 1'b1;
                        state_q <= S_CAPTURE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_CAPTURE: begin
                    // Record is frozen until the logger takes it
                    if (rec_ready) begin
                        valid_q <= 1'b0;
                        if (idx_q == LAST_VEC) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            idx_q   <= idx_q + N_WIDTH'(1);
                            state_q <= S_APPLY;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign vec_out    = vec_q;
    assign rec_valid  = valid_q;
    assign rec_vec    = rvec_q;
    assign rec_resp   = rresp_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign signature  = sig_q;
    assign ones_count = ones_q;

endmodule

// File: tb/tb_exhaustive_vector_sequencer.sv
// Bench for exhaustive_vector_sequencer: table of full sweeps on two
// instances (settle 1 and settle 3) plus a mid-run reset sequence.
module tb_exhaustive_vector_sequencer;

    logic CK = 1'b0;
    logic reset;
    logic start;
    logic rec_ready;
    logic sel;
    logic mode;

    always #5 CK = ~CK;

    logic [2:0]  vo_a, vo_b, rvec_a, rvec_b;
    logic        resp_a, resp_b, rv_a, rv_b, rr_a, rr_b;
    logic        bsy_a, bsy_b, dn_a, dn_b;
    logic [15:0] sig_a, sig_b;
    logic [3:0]  ones_a, ones_b;
    logic        p1_b, p2_b;

    // Instance A sees a combinational DUT; B sees one delayed by two flops
    assign resp_a = mode ? ^vo_a : &vo_a;
    always @(posedge CK) begin
        p1_b <= mode ? ^vo_b : &vo_b;
        p2_b <= p1_b;
    end
    assign resp_b = p2_b;

    exhaustive_vector_sequencer #(.SETTLE_CYCLES(1)) u_a (
        .CK(CK), .reset(reset), .start(start & ~sel),
        .vec_out(vo_a), .dut_resp(resp_a),
        .rec_valid(rv_a), .rec_ready(rec_ready),
        .rec_vec(rvec_a), .rec_resp(rr_a),
        .busy(bsy_a), .done(dn_a),
        .signature(sig_a), .ones_count(ones_a)
    );

    exhaustive_vector_sequencer #(.SETTLE_CYCLES(3)) u_b (
        .CK(CK), .reset(reset), .start(start & sel),
        .vec_out(vo_b), .dut_resp(resp_b),
        .rec_valid(rv_b), .rec_ready(rec_ready),
        .rec_vec(rvec_b), .rec_resp(rr_b),
        .busy(bsy_b), .done(dn_b),
        .signature(sig_b), .ones_count(ones_b)
    );

    logic [2:0]  vo, rvec;
    logic        rv, rr, bsy, dn;
    logic [15:0] sig;
    logic [3:0]  ones;
    assign vo   = sel ? vo_b   : vo_a;
    assign rvec = sel ? rvec_b : rvec_a;
    assign rv   = sel ? rv_b   : rv_a;
    assign rr   = sel ? rr_b   : rr_a;
    assign bsy  = sel ? bsy_b  : bsy_a;
    assign dn   = sel ? dn_b   : dn_a;
    assign sig  = sel ? sig_b  : sig_a;
    assign ones = sel ? ones_b : ones_a;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        sel;
        logic        mode;
        logic [3:0]  stall_vec;
        int          stall_len;
        logic [3:0]  poke_vec;
        logic [7:0]  exp_resp;
        logic [3:0]  exp_ones;
        logic [15:0] exp_sig;
        int          exp_edges;
    } sweep_t;

    sweep_t tbl[6];

    task automatic check_reset_vals(input string tag);
        check({tag, " vec_out"},   32'(vo),   0);
        check({tag, " rec_valid"}, 32'(rv),   0);
        check({tag, " rec_vec"},   32'(rvec), 0);
        check({tag, " rec_resp"},  32'(rr),   0);
        check({tag, " busy"},      32'(bsy),  0);
        check({tag, " done"},      32'(dn),   0);
        check({tag, " signature"}, 32'(sig),  0);
        check({tag, " ones"},      32'(ones), 0);
    endtask

    task automatic run_sweep(input sweep_t t, input int id);
        int         edges;
        int         recs;
        int         stall_left;
        bit         prev_valid;
        bit         finished;
        logic [2:0] hold_vec;
        logic [15:0] hold_sig;
        logic [3:0] hold_ones;
        string      tag;
        tag = $sformatf("sweep%0d", id);
        sel = t.sel;
        mode = t.mode;
        rec_ready = 1'b1;
        @(negedge CK);
        start = 1'b1;
        @(posedge CK);
        #1 start = 1'b0;
        check({tag, " busy@start"}, 32'(bsy), 1);
        check({tag, " done@start"}, 32'(dn), 0);
        check({tag, " sig@start"}, 32'(sig), 0);
        check({tag, " ones@start"}, 32'(ones), 0);
        edges = 0;
        recs = 0;
        stall_left = 0;
        prev_valid = 1'b0;
        finished = 1'b0;
        hold_vec = '0;
        hold_sig = '0;
        hold_ones = '0;
        while (!finished && edges < 200) begin
            @(posedge CK);
            #1;
            edges++;
            start = 1'b0;
            if (dn) begin
                finished = 1'b1;
            end else if (rv) begin
                if (!prev_valid) begin
                    if (recs < 8) begin
                        check({tag, " rec_vec"}, 32'(rvec), 32'(recs));
                        check({tag, " rec_resp"}, 32'(rr), 32'(t.exp_resp[recs]));
                        check({tag, " vec_out"}, 32'(vo), 32'(recs));
                    end
                    recs++;
                    if ({1'b0, rvec} == t.stall_vec && t.stall_len > 0) begin
                        rec_ready = 1'b0;
                        stall_left = t.stall_len;
                        hold_vec = rvec;
                        hold_sig = sig;
                        hold_ones = ones;
                    end
                    if ({1'b0, rvec} == t.poke_vec)
                        start = 1'b1;
                end else if (stall_left > 0) begin
                    check({tag, " stall rec_vec"}, 32'(rvec), 32'(hold_vec));
                    check({tag, " stall vec_out"}, 32'(vo), 32'(hold_vec));
                    check({tag, " stall sig"}, 32'(sig), 32'(hold_sig));
                    check({tag, " stall ones"}, 32'(ones), 32'(hold_ones));
                    stall_left--;
                    if (stall_left == 0)
                        rec_ready = 1'b1;
                end
            end
            prev_valid = rv;
        end
        rec_ready = 1'b1;
        check({tag, " finished"}, 32'(finished), 1);
        check({tag, " edges"}, 32'(edges), 32'(t.exp_edges));
        check({tag, " records"}, 32'(recs), 8);
        check({tag, " ones"}, 32'(ones), 32'(t.exp_ones));
        check({tag, " signature"}, 32'(sig), 32'(t.exp_sig));
        check({tag, " busy@done"}, 32'(bsy), 0);
        check({tag, " vec_out@done"}, 32'(vo), 7);
        repeat (3) @(posedge CK);
        #1;
        check({tag, " done held"}, 32'(dn), 1);
        check({tag, " sig held"}, 32'(sig), 32'(t.exp_sig));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int waited;
        tbl[0] = '{1'b0, 1'b0, 4'hF, 0, 4'hF, 8'h80, 4'd1, 16'h0001, 24};
        tbl[1] = '{1'b0, 1'b1, 4'hF, 0, 4'hF, 8'h96, 4'd4, 16'h0069, 24};
        tbl[2] = '{1'b0, 1'b1, 4'h3, 5, 4'hF, 8'h96, 4'd4, 16'h0069, 29};
        tbl[3] = '{1'b1, 1'b1, 4'hF, 0, 4'hF, 8'h96, 4'd4, 16'h0069, 40};
        tbl[4] = '{1'b0, 1'b1, 4'hF, 0, 4'h2, 8'h96, 4'd4, 16'h0069, 24};
        tbl[5] = '{1'b0, 1'b1, 4'hF, 0, 4'hF, 8'h96, 4'd4, 16'h0069, 24};

        reset = 1'b1;
        start = 1'b0;
        rec_ready = 1'b1;
        sel = 1'b0;
        mode = 1'b0;
        #12;
        check_reset_vals("reset");
        sel = 1'b1;
        check_reset_vals("resetB");
        sel = 1'b0;
        @(negedge CK);
        reset = 1'b0;

        for (int i = 0; i < 6; i++)
            run_sweep(tbl[i], i);

        sel = 1'b0;
        mode = 1'b1;
        @(negedge CK);
        start = 1'b1;
        @(posedge CK);
        #1 start = 1'b0;
        waited = 0;
        while (vo != 3'd4 && waited < 100) begin
            @(posedge CK);
            #1;
            waited++;
        end
        check("midrun reached 100", 32'(vo), 4);
        #2 reset = 1'b1;
        #1;
        check_reset_vals("midrun");
        @(negedge CK);
        reset = 1'b0;
        run_sweep(tbl[1], 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
